// File: rtl/pico_ctrl_pkg.sv
// Shared opcode, ALU-function and state definitions for the picoMIPS control unit.
// The HALTED state exists only when PICO_HALT_EN is defined.
package pico_ctrl_pkg;

   localparam logic [31:0] OP_ADD  = 32'd0;
   localparam logic [31:0] OP_ADDI = 32'd1;
   localparam logic [31:0] OP_MUL  = 32'd2;
   localparam logic [31:0] OP_LDI  = 32'd3;
   localparam logic [31:0] OP_BEQ  = 32'd4;
   localparam logic [31:0] OP_BNE  = 32'd5;
   localparam logic [31:0] OP_NOP  = 32'd6;
   localparam logic [31:0] OP_HALT = 32'd7;

   // ALU select codes mirror the opcode values of the instructions that use them
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_ADDI = 3'd1;
   localparam logic [2:0] ALU_MUL  = 3'd2;
   localparam logic [2:0] ALU_LDI  = 3'd3;
   localparam logic [2:0] ALU_NOP  = 3'd0;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_DECODE   = 2'd1,
      ST_MUL_WAIT = 2'd2
`ifdef PICO_HALT_EN
      ,ST_HALTED  = 2'd3
`endif
   } state_e;

endpackage

// File: rtl/pico_mcycle_cnt.sv
// Down-counter that times the extra cycles of a multi-cycle MUL.
// Loads MUL_CYCLES-2, decrements on request and flags when it reaches zero.
module pico_mcycle_cnt #(
   parameter int MUL_CYCLES = 1
) (
   input  logic clk,
   input  logic n_reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [3:0] LOAD_VAL = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

   logic [3:0] cnt_r;

   // Counter register: load wins over decrement
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt_r <= 4'd0;
      end else if (load) begin
         cnt_r <= LOAD_VAL;
      end else if (dec) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/pico_ctrl_unit.sv
// Multi-cycle picoMIPS control unit: opcode decode, branch flag, MUL stall, boot and illegal tracking.
// Optional HALT support is enabled by defining PICO_HALT_EN.
module pico_ctrl_unit
   import pico_ctrl_pkg::*;
#(
   parameter int OPW        = 4,
   parameter int ALUFW      = 3,
   parameter int MUL_CYCLES = 1
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [OPW-1:0]   opcode,
   input  logic             instr_valid,
   input  logic             alu_zero,
   output logic             pc_incr,
   output logic             pc_relbranch,
   output logic [ALUFW-1:0] alu_func,
   output logic             imm,
   output logic             w,
   output logic             mul_busy,
   output logic             illegal,
   output logic             halted
);

   state_e            state_r;
   state_e            state_nxt_s;
   logic              z_r;
   logic              illegal_r;
   logic [31:0]       op_s;
   logic              pc_incr_s;
   logic              pc_relbranch_s;
   logic [ALUFW-1:0]  alu_func_s;
   logic              imm_s;
   logic              w_s;
   logic              mul_busy_s;
   logic              illegal_set_s;
   logic              cnt_load_s;
   logic              cnt_dec_s;
   logic              cnt_zero_s;

   pico_mcycle_cnt #(
      .MUL_CYCLES (MUL_CYCLES)
   ) u_cnt (
      .clk     (clk),
      .n_reset (n_reset),
      .load    (cnt_load_s),
      .dec     (cnt_dec_s),
      .zero    (cnt_zero_s)
   );

   // Next-state and control decode; every control starts at its idle value
   always_comb begin
      state_nxt_s    = state_r;
      op_s           = 32'(opcode);
      pc_incr_s      = 1'b0;
      pc_relbranch_s = 1'b0;
      alu_func_s     = ALUFW'(ALU_NOP);
      imm_s          = 1'b0;
      w_s            = 1'b0;
      mul_busy_s     = 1'b0;
      illegal_set_s  = 1'b0;
      cnt_load_s     = 1'b0;
      cnt_dec_s      = 1'b0;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s = ST_DECODE;
         end
         ST_DECODE: begin
            pc_incr_s = 1'b1;
            if (instr_valid) begin
               case (op_s)
                  OP_ADD, OP_LDI: begin
                     alu_func_s = ALUFW'(op_s);
                     w_s        = 1'b1;
                  end
                  OP_ADDI: begin
                     alu_func_s = ALUFW'(op_s);
                     w_s        = 1'b1;
                     imm_s      = 1'b1;
                  end
                  OP_MUL: begin
                     alu_func_s = ALUFW'(op_s);
                     imm_s      = 1'b1;
                     if (MUL_CYCLES > 1) begin
                        pc_incr_s   = 1'b0;
                        cnt_load_s  = 1'b1;
                        state_nxt_s = ST_MUL_WAIT;
                     end else begin
                        w_s = 1'b1;
                     end
                  end
                  OP_BEQ, OP_BNE: begin
                     alu_func_s = ALUFW'(op_s);
                     // BEQ branches on a set flag, BNE on a clear one
                     if (z_r == (op_s == OP_BEQ)) begin
                        pc_incr_s      = 1'b0;
                        pc_relbranch_s = 1'b1;
                     end else begin
                        pc_incr_s      = 1'b1;
                     end
                  end
                  OP_NOP: begin
                     pc_incr_s = 1'b1;
                  end
`ifdef PICO_HALT_EN
                  OP_HALT: begin
                     pc_incr_s   = 1'b0;
                     state_nxt_s = ST_HALTED;
                  end
`endif
                  default: begin
                     illegal_set_s = 1'b1;
                  end
               endcase
            end else begin
               pc_incr_s = 1'b1;
            end
         end
         ST_MUL_WAIT: begin
            alu_func_s = ALUFW'(ALU_MUL);
            imm_s      = 1'b1;
            mul_busy_s = 1'b1;
            if (cnt_zero_s) begin
               w_s         = 1'b1;
               pc_incr_s   = 1'b1;
               state_nxt_s = ST_DECODE;
            end else begin
               cnt_dec_s   = 1'b1;
            end
         end
`ifdef PICO_HALT_EN
         ST_HALTED: begin
            state_nxt_s = ST_HALTED;
         end
`endif
         default: begin
            state_nxt_s = ST_BOOT;
         end
      endcase
   end

   // State, zero flag and sticky illegal registers
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_r   <= ST_BOOT;
         z_r       <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (w_s) begin
            z_r <= alu_zero;
         end else begin
            z_r <= z_r;
         end
         if (illegal_set_s) begin
            illegal_r <= 1'b1;
         end else begin
            illegal_r <= illegal_r;
         end
      end
   end

   assign pc_incr      = pc_incr_s;
   assign pc_relbranch = pc_relbranch_s;
   assign alu_func     = alu_func_s;
   assign imm          = imm_s;
   assign w            = w_s;
   assign mul_busy     = mul_busy_s;
   assign illegal      = illegal_r;
`ifdef PICO_HALT_EN
   assign halted       = (state_r == ST_HALTED);
`else
   assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_pico_ctrl_unit.sv
// Directed self-checking bench for pico_ctrl_unit (4-cycle MUL instance plus a single-cycle MUL instance).
module tb_pico_ctrl_unit;

   logic       clk;
   logic       n_reset;
   logic [3:0] opcode;
   logic       instr_valid;
   logic       alu_zero;

   logic       pc_incr, pc_relbranch, imm, w, mul_busy, illegal, halted;
   logic [2:0] alu_func;
   logic       pc_incr1, pc_relbranch1, imm1, w1, mul_busy1, illegal1, halted1;
   logic [2:0] alu_func1;

   int checks   = 0;
   int failures = 0;

   pico_ctrl_unit #(.OPW(4), .ALUFW(3), .MUL_CYCLES(4)) dut (
      .clk(clk), .n_reset(n_reset), .opcode(opcode), .instr_valid(instr_valid),
      .alu_zero(alu_zero), .pc_incr(pc_incr), .pc_relbranch(pc_relbranch),
      .alu_func(alu_func), .imm(imm), .w(w), .mul_busy(mul_busy),
      .illegal(illegal), .halted(halted)
   );

   pico_ctrl_unit #(.OPW(4), .ALUFW(3), .MUL_CYCLES(1)) dut1 (
      .clk(clk), .n_reset(n_reset), .opcode(opcode), .instr_valid(instr_valid),
      .alu_zero(alu_zero), .pc_incr(pc_incr1), .pc_relbranch(pc_relbranch1),
      .alu_func(alu_func1), .imm(imm1), .w(w1), .mul_busy(mul_busy1),
      .illegal(illegal1), .halted(halted1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input bit pi, input bit pb, input logic [2:0] af,
                          input bit im, input bit ww, input bit mb, input bit il, input bit hl);
      chk({tag, ".pc_incr"},      32'(pc_incr),      32'(pi));
      chk({tag, ".pc_relbranch"}, 32'(pc_relbranch), 32'(pb));
      chk({tag, ".alu_func"},     32'(alu_func),     32'(af));
      chk({tag, ".imm"},          32'(imm),          32'(im));
      chk({tag, ".w"},            32'(w),            32'(ww));
      chk({tag, ".mul_busy"},     32'(mul_busy),     32'(mb));
      chk({tag, ".illegal"},      32'(illegal),      32'(il));
      chk({tag, ".halted"},       32'(halted),       32'(hl));
   endtask

   // Apply inputs just after a falling edge and settle before the next rising edge
   task automatic drive(input logic [3:0] op, input logic vld, input logic az);
      @(negedge clk);
      opcode      = op;
      instr_valid = vld;
      alu_zero    = az;
      #2;
   endtask

   task automatic do_reset();
      #1 n_reset = 1'b0;
      drive(4'd0, 1'b1, 1'b0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("rst", 0, 0, 3'd0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_reset = 1'b1;
      #2;
      chk_all("boot", 0, 0, 3'd0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_reset     = 1'b0;
      opcode      = 4'd0;
      instr_valid = 1'b1;
      alu_zero    = 1'b0;

      // Reset, BOOT with ADD presented, then ADD decodes
      drive(4'd0, 1'b1, 1'b0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("rst0", 0, 0, 3'd0, 0, 0, 0, 0, 0);
      chk("rst0.mcnt", 32'(dut.u_cnt.cnt_r), 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      #2;
      chk_all("boot0", 0, 0, 3'd0, 0, 0, 0, 0, 0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("add", 1, 0, 3'd0, 0, 1, 0, 0, 0);

      // Flag writes and branches
      drive(4'd1, 1'b1, 1'b1);
      chk_all("addi_z1", 1, 0, 3'd1, 1, 1, 0, 0, 0);
      drive(4'd4, 1'b1, 1'b0);
      chk_all("beq_taken", 0, 1, 3'd4, 0, 0, 0, 0, 0);
      drive(4'd5, 1'b1, 1'b0);
      chk_all("bne_not", 1, 0, 3'd5, 0, 0, 0, 0, 0);
      drive(4'd1, 1'b1, 1'b0);
      chk_all("addi_z0", 1, 0, 3'd1, 1, 1, 0, 0, 0);
      drive(4'd5, 1'b1, 1'b1);
      chk_all("bne_taken", 0, 1, 3'd5, 0, 0, 0, 0, 0);
      drive(4'd4, 1'b1, 1'b1);
      chk_all("beq_not", 1, 0, 3'd4, 0, 0, 0, 0, 0);
      drive(4'd3, 1'b1, 1'b1);
      chk_all("ldi_z1", 1, 0, 3'd3, 0, 1, 0, 0, 0);
      drive(4'd0, 1'b0, 1'b0);
      chk_all("invalid", 1, 0, 3'd0, 0, 0, 0, 0, 0);
      drive(4'd4, 1'b1, 1'b0);
      chk_all("beq_after_inv", 0, 1, 3'd4, 0, 0, 0, 0, 0);
      drive(4'd6, 1'b1, 1'b0);
      chk_all("nop", 1, 0, 3'd0, 0, 0, 0, 0, 0);

      // Four-cycle MUL; opcodes during the wait are ignored; flag taken from final cycle
      drive(4'd2, 1'b1, 1'b1);
      chk_all("mul_c1", 0, 0, 3'd2, 1, 0, 0, 0, 0);
      chk("mul1.w",        32'(w1),        32'd1);
      chk("mul1.imm",      32'(imm1),      32'd1);
      chk("mul1.pc_incr",  32'(pc_incr1),  32'd1);
      chk("mul1.mul_busy", 32'(mul_busy1), 32'd0);
      chk("mul1.alu_func", 32'(alu_func1), 32'd2);
      drive(4'd9, 1'b1, 1'b1);
      chk_all("mul_c2", 0, 0, 3'd2, 1, 0, 1, 0, 0);
      drive(4'd7, 1'b1, 1'b1);
      chk_all("mul_c3", 0, 0, 3'd2, 1, 0, 1, 0, 0);
      drive(4'd4, 1'b1, 1'b0);
      chk_all("mul_c4", 1, 0, 3'd2, 1, 1, 1, 0, 0);
      drive(4'd5, 1'b1, 1'b1);
      chk_all("bne_after_mul", 0, 1, 3'd5, 0, 0, 0, 0, 0);

      // Reset during cycle 2 of a MUL aborts it without a write
      drive(4'd2, 1'b1, 1'b0);
      chk_all("abort_c1", 0, 0, 3'd2, 1, 0, 0, 0, 0);
      drive(4'd2, 1'b1, 1'b0);
      chk_all("abort_c2", 0, 0, 3'd2, 1, 0, 1, 0, 0);
      #1 n_reset = 1'b0;
      #1;
      chk_all("abort_rst", 0, 0, 3'd0, 0, 0, 0, 0, 0);
      chk("abort.mcnt", 32'(dut.u_cnt.cnt_r), 32'd0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("abort_hold", 0, 0, 3'd0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_reset = 1'b1;
      #2;
      chk_all("abort_boot", 0, 0, 3'd0, 0, 0, 0, 0, 0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("abort_add", 1, 0, 3'd0, 0, 1, 0, 0, 0);

      // Out-of-range opcode: NOP outputs, sticky illegal from the next edge
      drive(4'd9, 1'b1, 1'b0);
      chk_all("op9", 1, 0, 3'd0, 0, 0, 0, 0, 0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("op9_next", 1, 0, 3'd0, 0, 1, 0, 1, 0);
      drive(4'd3, 1'b1, 1'b0);
      chk_all("op9_sticky", 1, 0, 3'd3, 0, 1, 0, 1, 0);

      // HALT behaviour depends on build configuration
      do_reset();
      drive(4'd7, 1'b1, 1'b0);
`ifdef PICO_HALT_EN
      chk("halt_c1.halted",  32'(halted),  32'd0);
      chk("halt_c1.w",       32'(w),       32'd0);
      chk("halt_c1.illegal", 32'(illegal), 32'd0);
      for (int i = 0; i < 11; i++) begin
         drive(4'(i), 1'b1, 1'b0);
         chk_all($sformatf("halted%0d", i), 0, 0, 3'd0, 0, 0, 0, 0, 1);
      end
      do_reset();
      drive(4'd0, 1'b1, 1'b0);
      chk_all("halt_exit_add", 1, 0, 3'd0, 0, 1, 0, 0, 0);
`else
      chk_all("halt_as_illegal", 1, 0, 3'd0, 0, 0, 0, 0, 0);
      drive(4'd0, 1'b1, 1'b0);
      chk_all("halt_illegal_next", 1, 0, 3'd0, 0, 1, 0, 1, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
